fft_input_pair_buffer: RTL

//  Input-side reorder buffer of the 32-point radix-2 DIF FFT datapath. Accepts one sample per

---
 rtl/fft_pkg.sv | 12 +
 rtl/fft_bank_regfile.sv | 29 ++
 rtl/fft_input_pair_buffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the 32-point FFT input reorder buffer.
package fft_pkg;
  localparam int WORD_LEN = 11;
  localparam int N_FFT    = 32;
  localparam int HALF_N   = N_FFT / 2;
  localparam int LOG2_N   = $clog2(N_FFT);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } fft_state_e;
endpackage

// File: rtl/fft_bank_regfile.sv
// One frame bank: single write port, two combinational read ports returning x[k] and x[k+16].
module fft_bank_regfile
  import fft_pkg::*;
(
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_we,
  input  logic [LOG2_N-1:0]          i_waddr,
  input  logic signed [WORD_LEN-1:0] i_wdata,
  input  logic [LOG2_N-2:0]          i_raddr,
  output logic signed [WORD_LEN-1:0] o_rdata_up,
  output logic signed [WORD_LEN-1:0] o_rdata_dn
);

  logic signed [WORD_LEN-1:0] r_mem [N_FFT];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_FFT; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Upper half of the address space holds the partner sample k+16.
  assign o_rdata_up = r_mem[{1'b0, i_raddr}];
  assign o_rdata_dn = r_mem[{1'b1, i_raddr}];

endmodule

// File: rtl/fft_input_pair_buffer.sv
// Ping-pong input buffer feeding (x[k], x[k+16]) pairs to the first DIF butterfly stage.
// Optional SOF_ALIGN_EN adds in_sof, which restarts the current frame at address 0.
module fft_input_pair_buffer
  import fft_pkg::*;
(
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic signed [WORD_LEN-1:0] DataIn,
  input  logic                       in_valid,
`ifdef SOF_ALIGN_EN
  input  logic                       in_sof,
`endif
  output logic signed [WORD_LEN-1:0] DataOutUp,
  output logic signed [WORD_LEN-1:0] DataOutDown,
  output logic                       out_valid
);

  logic [LOG2_N-1:0]          r_wr_cnt;
  logic [LOG2_N-2:0]          r_rd_cnt;
  logic                       r_wr_bank;
  logic                       r_rd_bank;
  fft_state_e                 r_state;

  fft_state_e                 w_state_nxt;
  logic [LOG2_N-2:0]          w_rd_cnt_nxt;
  logic                       w_sof;
  logic                       w_frame_done;
  logic [LOG2_N-1:0]          w_waddr;
  logic                       w_we_a;
  logic                       w_we_b;
  logic signed [WORD_LEN-1:0] w_a_up;
  logic signed [WORD_LEN-1:0] w_a_dn;
  logic signed [WORD_LEN-1:0] w_b_up;
  logic signed [WORD_LEN-1:0] w_b_dn;

`ifdef SOF_ALIGN_EN
  assign w_sof = in_valid && in_sof;
`else
  assign w_sof = 1'b0;
`endif

  // A start-of-frame sample realigns the frame, so it can never complete one.
  assign w_frame_done = in_valid && !w_sof && (r_wr_cnt == LOG2_N'(N_FFT - 1));
  assign w_waddr      = w_sof ? '0 : r_wr_cnt;
  assign w_we_a       = in_valid && !r_wr_bank;
  assign w_we_b       = in_valid &&  r_wr_bank;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else if (w_sof) begin
      r_wr_cnt <= LOG2_N'(1);
    end else if (in_valid) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_frame_done) begin
        r_wr_bank <= ~r_wr_bank;
        r_rd_bank <= r_wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
    case (r_state)
      IDLE: begin
        if (w_frame_done) begin
          w_state_nxt  = READ;
          w_rd_cnt_nxt = '0;
        end
      end
      READ: begin
        if (w_frame_done) begin
          w_rd_cnt_nxt = '0;
        end else if (r_rd_cnt == (LOG2_N-1)'(HALF_N - 1)) begin
          w_state_nxt  = IDLE;
          w_rd_cnt_nxt = '0;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_rd_cnt_nxt = '0;
      end
    endcase
  end

  fft_bank_regfile u_bank_a (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_we       (w_we_a),
    .i_waddr    (w_waddr),
    .i_wdata    (DataIn),
    .i_raddr    (r_rd_cnt),
    .o_rdata_up (w_a_up),
    .o_rdata_dn (w_a_dn)
  );

  fft_bank_regfile u_bank_b (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_we       (w_we_b),
    .i_waddr    (w_waddr),
    .i_wdata    (DataIn),
    .i_raddr    (r_rd_cnt),
    .o_rdata_up (w_b_up),
    .o_rdata_dn (w_b_dn)
  );

  always_comb begin
    out_valid   = (r_state == READ);
    DataOutUp   = '0;
    DataOutDown = '0;
    if (r_state == READ) begin
      DataOutUp   = r_rd_bank ? w_b_up : w_a_up;
      DataOutDown = r_rd_bank ? w_b_dn : w_a_dn;
    end
  end

endmodule
